spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_controller.sv | 173 +++++++++++++++++
 tb/tb_spi_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 controller issuing 16-bit frames: {rw, addr[6:0], data[7:0]}, MSB first.
// SCLK half-period is CLK_DIV clk cycles (2..255). Each frame is followed by a
// CLK_DIV-cycle chip-select hold and a CLK_DIV-cycle deselected gap; done pulses
// on the last gap cycle.
// Optional feature macro: SPI_CONTROLLER_READ_EN. When defined, rw=0 frames
// capture cipo on the rising sclk edges of the data byte into rdata. When it is
// undefined, every frame is a write (bit15 forced to 1) and rdata stays 0.
module spi_controller #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       ncs,
    output logic       copi,
    input  logic       cipo
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned FRAME_W = 16;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_DONE  = CNT_W'(CLK_DIV - 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]     bit_q;
    logic [FRAME_W-1:0]   frame_q;
    logic [FRAME_W-1:0]   frame_d;
    logic                 ready_q;
    logic                 done_q;
    logic                 sclk_q;
    logic                 ncs_q;
    logic                 copi_q;
    logic [7:0]           rdata_q;

`ifdef SPI_CONTROLLER_READ_EN
    logic                 read_q;
    logic [7:0]           rx_q;

    // Frame to launch: reads carry a zero data byte
    always_comb begin
        frame_d = rw ? {1'b1, addr, wdata} : {1'b0, addr, 8'h00};
    end
`else
    logic                 unused_inputs;
    assign unused_inputs = rw ^ cipo;

    // Frame to launch: write-only build always sets the write bit
    always_comb begin
        frame_d = {1'b1, addr, wdata};
    end
`endif

    // Transaction sequencer: idle, 16-bit shift, chip-select hold, deselected gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
            rdata_q <= '0;
`ifdef SPI_CONTROLLER_READ_EN
            read_q  <= 1'b0;
            rx_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && ready_q) begin
                        state_q <= SHIFT;
                        ready_q <= 1'b0;
                        ncs_q   <= 1'b0;
                        sclk_q  <= 1'b0;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        frame_q <= frame_d;
                        copi_q  <= frame_d[FRAME_W-1];
`ifdef SPI_CONTROLLER_READ_EN
                        read_q  <= ~rw;
                        rx_q    <= '0;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt_q != HALF_LAST) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        cnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
`ifdef SPI_CONTROLLER_READ_EN
                            // Data byte occupies bit slots 8..15 of the frame
                            if (read_q && bit_q[BIT_W-1]) begin
                                rx_q <= {rx_q[6:0], cipo};
                            end
`endif
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == BIT_LAST) begin
                                state_q <= HOLD;
                                copi_q  <= 1'b0;
                            end else begin
                                bit_q   <= bit_q + BIT_W'(1);
                                frame_q <= frame_q << 1;
                                copi_q  <= frame_q[FRAME_W-2];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q != HALF_LAST) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                        state_q <= GAP;
                        ncs_q   <= 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_DONE) begin
                        done_q <= 1'b1;
`ifdef SPI_CONTROLLER_READ_EN
                        if (read_q) begin
                            rdata_q <= rx_q;
                        end
`endif
                    end
                    if (cnt_q != HALF_LAST) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign sclk  = sclk_q;
    assign ncs   = ncs_q;
    assign copi  = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: a CLK_DIV=4 instance runs a table of write and read
// frames plus busy and mid-frame-reset sequences; a CLK_DIV=2 instance runs back-to-back frames.
`timescale 1ns/1ps
module tb_spi_controller;

`ifdef SPI_CONTROLLER_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A, CLK_DIV=4
    logic       a_start, a_rw, a_ready, a_done, a_sclk, a_ncs, a_copi, a_cipo;
    logic [6:0] a_addr;
    logic [7:0] a_wdata, a_rdata;

    // Instance B, CLK_DIV=2
    logic       b_start, b_rw, b_ready, b_done, b_sclk, b_ncs, b_copi, b_cipo;
    logic [6:0] b_addr;
    logic [7:0] b_wdata, b_rdata;

    spi_controller #(.CLK_DIV(4)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .rw(a_rw), .addr(a_addr),
        .wdata(a_wdata), .ready(a_ready), .done(a_done), .rdata(a_rdata),
        .sclk(a_sclk), .ncs(a_ncs), .copi(a_copi), .cipo(a_cipo)
    );

    spi_controller #(.CLK_DIV(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .rw(b_rw), .addr(b_addr),
        .wdata(b_wdata), .ready(b_ready), .done(b_done), .rdata(b_rdata),
        .sclk(b_sclk), .ncs(b_ncs), .copi(b_copi), .cipo(b_cipo)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- Instance A monitor / cipo peripheral model ----------------
    int          cyc = 0;
    logic        a_psclk = 1'b0, a_pncs = 1'b1, a_pcopi = 1'b0;
    logic [15:0] a_cap = '0, a_cipo_sr = '0, a_cipo_pat = '0;
    int          a_rises = 0, a_nlow = 0, a_dones = 0, a_frames = 0, a_glitch = 0;
    int          a_acc_cyc = 0, a_done_cyc = 0;

    assign a_cipo = a_cipo_sr[15];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (a_start && a_ready) a_acc_cyc <= cyc;
        if (a_ncs === 1'b0) begin
            if (a_pncs) begin
                a_cap     <= '0;
                a_rises   <= 0;
                a_nlow    <= 1;
                a_frames  <= a_frames + 1;
                a_cipo_sr <= a_cipo_pat;
            end else begin
                a_nlow <= a_nlow + 1;
                if (a_psclk && !a_sclk) a_cipo_sr <= a_cipo_sr << 1;
                if (a_sclk && !a_psclk) begin
                    a_cap   <= {a_cap[14:0], a_copi};
                    a_rises <= a_rises + 1;
                end
            end
        end else if (a_sclk) begin
            a_glitch <= a_glitch + 1;
        end
        if (a_sclk && a_psclk && (a_copi !== a_pcopi)) a_glitch <= a_glitch + 1;
        if (a_done) begin
            a_dones    <= a_dones + 1;
            a_done_cyc <= cyc;
        end
        a_psclk <= a_sclk;
        a_pncs  <= a_ncs;
        a_pcopi <= a_copi;
    end

    // ---------------- Instance B monitor (frame log) ----------------
    logic        b_psclk = 1'b0, b_pncs = 1'b1, b_pcopi = 1'b0;
    logic [15:0] b_cap = '0;
    int          b_rises = 0, b_nlow = 0, b_nhigh = 0, b_dones = 0, b_frames = 0, b_glitch = 0;
    logic [15:0] b_frame_log [4];
    int          b_nlow_log  [4];
    int          b_rise_log  [4];
    int          b_gap_log   [4];

    assign b_cipo = 1'b0;

    always @(negedge clk) begin
        if (b_ncs === 1'b0) begin
            if (b_pncs) begin
                b_cap   <= '0;
                b_rises <= 0;
                b_nlow  <= 1;
                if (b_frames > 0 && b_frames <= 4) b_gap_log[b_frames-1] <= b_nhigh;
            end else begin
                b_nlow <= b_nlow + 1;
                if (b_sclk && !b_psclk) begin
                    b_cap   <= {b_cap[14:0], b_copi};
                    b_rises <= b_rises + 1;
                end
            end
        end else begin
            if (b_sclk) b_glitch <= b_glitch + 1;
            if (!b_pncs) begin
                if (b_frames < 4) begin
                    b_frame_log[b_frames] <= b_cap;
                    b_nlow_log[b_frames]  <= b_nlow;
                    b_rise_log[b_frames]  <= b_rises;
                end
                b_frames <= b_frames + 1;
                b_nhigh  <= 1;
            end else begin
                b_nhigh <= b_nhigh + 1;
            end
        end
        if (b_sclk && b_psclk && (b_copi !== b_pcopi)) b_glitch <= b_glitch + 1;
        if (b_done) b_dones <= b_dones + 1;
        b_psclk <= b_sclk;
        b_pncs  <= b_ncs;
        b_pcopi <= b_copi;
    end

    // ---------------- Vector table ----------------
    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] cipo_pat;
        logic [15:0] exp_frame;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one frame on instance A and wait (bounded) for its done pulse
    task automatic launch_a(input vec_t v, output bit ok);
        int d0;
        d0 = a_dones;
        a_cipo_pat = v.cipo_pat;
        a_rw    = v.rw;
        a_addr  = v.addr;
        a_wdata = v.wdata;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_rw    = ~v.rw;
        a_addr  = ~v.addr;
        a_wdata = ~v.wdata;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (a_dones != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int d0, f0;

        vecs[0] = '{1'b1, 7'h04, 8'hA5, 16'h0000, 16'h84A5, 8'h00};
        vecs[1] = '{1'b1, 7'h7F, 8'hFF, 16'h0000, 16'hFFFF, 8'h00};
        vecs[2] = '{1'b1, 7'h00, 8'h00, 16'hFFFF, 16'h8000, 8'h00};
        vecs[3] = '{1'b1, 7'h55, 8'h3C, 16'h0000, 16'hD53C, 8'h00};
        vecs[4] = '{1'b0, 7'h01, 8'h00, 16'hC33C,
                    READ_EN ? 16'h0100 : 16'h8100, READ_EN ? 8'h3C : 8'h00};
        vecs[5] = '{1'b0, 7'h7E, 8'h00, 16'h5AA5,
                    READ_EN ? 16'h7E00 : 16'hFE00, READ_EN ? 8'hA5 : 8'h00};

        rst_n   = 1'b0;
        a_start = 1'b0; a_rw = 1'b0; a_addr = '0; a_wdata = '0;
        b_start = 1'b0; b_rw = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) tick();

        // Reset state
        check("rst ncs",   a_ncs,   1'b1);
        check("rst sclk",  a_sclk,  1'b0);
        check("rst copi",  a_copi,  1'b0);
        check("rst done",  a_done,  1'b0);
        check("rst rdata", a_rdata, 8'h00);
        #2 rst_n = 1'b1;
        tick();
        check("ready after reset", a_ready, 1'b1);
        repeat (2) tick();

        // Table of single frames on instance A
        for (int i = 0; i < 6; i++) begin
            check($sformatf("v%0d ready", i), a_ready, 1'b1);
            launch_a(vecs[i], ok);
            check($sformatf("v%0d done seen", i), ok, 1'b1);
            check($sformatf("v%0d frame", i), a_cap, vecs[i].exp_frame);
            check($sformatf("v%0d sclk rises", i), a_rises, 16);
            check($sformatf("v%0d ncs low cycles", i), a_nlow, 132);
            check($sformatf("v%0d latency", i), a_done_cyc - a_acc_cyc, 136);
            if (!vecs[i].rw || !READ_EN)
                check($sformatf("v%0d rdata", i), a_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d ready after", i), a_ready, 1'b1);
            repeat (3) tick();
        end

        // Busy: a second start mid-frame is dropped, not queued
        d0 = a_dones;
        f0 = a_frames;
        a_cipo_pat = '0;
        a_rw = 1'b1; a_addr = 7'h04; a_wdata = 8'hA5; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (50) tick();
        check("busy ready low", a_ready, 1'b0);
        check("busy ncs low",   a_ncs,   1'b0);
        a_addr = 7'h7F; a_wdata = 8'h00; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (250) tick();
        check("busy frame", a_cap, 16'h84A5);
        check("busy done count", a_dones - d0, 1);
        check("busy frame count", a_frames - f0, 1);
        check("busy idle ncs", a_ncs, 1'b1);

        // Mid-frame reset: immediate idle outputs, no resume, no done
        a_rw = 1'b1; a_addr = 7'h7F; a_wdata = 8'hFF; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (70) tick();
        d0 = a_dones;
        f0 = a_frames;
        #2 rst_n = 1'b0;
        #1;
        check("midrst ncs",   a_ncs,   1'b1);
        check("midrst sclk",  a_sclk,  1'b0);
        check("midrst copi",  a_copi,  1'b0);
        check("midrst done",  a_done,  1'b0);
        check("midrst rdata", a_rdata, 8'h00);
        tick();
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("midrst ready after release", a_ready, 1'b1);
        repeat (200) tick();
        check("midrst no done",   a_dones - d0,  0);
        check("midrst no resume", a_frames - f0, 0);
        check("midrst ncs idle",  a_ncs, 1'b1);

        // Back-to-back on instance B with start held high
        b_rw = 1'b1; b_addr = 7'h12; b_wdata = 8'h34; b_start = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (b_dones >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        b_start = 1'b0;
        check("b2b three dones", ok, 1'b1);
        repeat (100) tick();
        check("b2b done count",  b_dones,  3);
        check("b2b frame count", b_frames, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b f%0d frame", i), b_frame_log[i], 16'h9234);
            check($sformatf("b2b f%0d ncs low", i), b_nlow_log[i], 66);
            check($sformatf("b2b f%0d rises", i), b_rise_log[i], 16);
        end
        for (int i = 0; i < 2; i++)
            check($sformatf("b2b gap%0d >= 3", i), b_gap_log[i] >= 3, 1'b1);

        check("a copi/sclk glitches", a_glitch, 0);
        check("b copi/sclk glitches", b_glitch, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
